// File: rtl/dram_arbiter.sv
// Round-robin arbiter and access sequencer sharing one DRAM port between two requesters.
// Byte-masked stores are merged with the current word inside the single ACCESS cycle.
`timescale 1ns/1ps

module dram_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_sel,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_sel,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,

  output logic [ADDR_W-1:0] dram_a,
  output logic              dram_we,
  output logic [31:0]       dram_d,
  input  logic [31:0]       dram_spo,

  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata0_q, rdata0_d;
  logic [31:0]         rdata1_q, rdata1_d;
  logic [31:0]         merged;
  logic                in_access;

  // Byte-offset and above-range address bits never reach the DRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                              m1_addr[31:ADDR_W+2], m1_addr[1:0]};

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    logic win;
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    win          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the requester that did not win last time goes first.
          win          = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          owner_d      = win;
          last_grant_d = win;
          we_d         = win ? m1_we    : m0_we;
          sel_d        = win ? m1_sel   : m0_sel;
          addr_d       = win ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
          wdata_d      = win ? m1_wdata : m0_wdata;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (owner_q) rdata1_d = dram_spo;
        else         rdata0_d = dram_spo;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 4'b0;
      addr_q       <= '0;
      wdata_q      <= 32'b0;
      rdata0_q     <= 32'b0;
      rdata1_q     <= 32'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    merged = dram_spo;
    for (int i = 0; i < 4; i++) begin
      if (sel_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Write strobe is decoded from state only, so reset kills it immediately.
  assign in_access = (state_q == ACCESS);
  assign dram_a    = addr_q;
  assign dram_we   = in_access & we_q & (|sel_q);
  assign dram_d    = in_access ? merged : 32'b0;

  assign m0_ack    = (state_q == RESP) & ~owner_q;
  assign m1_ack    = (state_q == RESP) &  owner_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios, then random traffic
// compared against a transaction-level model (round-robin pick + word memory).
`timescale 1ns/1ps

module tb_dram_arbiter;

  localparam int ADDR_W = 14;

  logic              cpu_clk;
  logic              cpu_rst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [3:0]        m0_sel, m1_sel;
  logic [31:0]       m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic              m0_ack, m1_ack;
  logic [31:0]       m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] dram_a;
  logic              dram_we;
  logic [31:0]       dram_d, dram_spo;
  logic              owner;

  dram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .dram_a(dram_a), .dram_we(dram_we), .dram_d(dram_d), .dram_spo(dram_spo),
    .owner(owner)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // DRAM instance: asynchronous read, synchronous write, plus a preload port.
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [31:0]       pl_data;
  int                we_cnt = 0;

  assign dram_spo = mem[dram_a];
  always @(posedge cpu_clk) begin
    if (dram_we) begin
      mem[dram_a] <= dram_d;
      we_cnt      <= we_cnt + 1;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [31:0] exp_rd  [0:1];
  logic        rr_last;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
    return (wd & m) | (old & ~m);
  endfunction

  task automatic preload(input int word, input logic [31:0] val);
    pl_en   = 1'b1;
    pl_addr = word[ADDR_W-1:0];
    pl_data = val;
    ref_mem[word] = val;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_req(input int m, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();
    cpu_rst = 1'b0;
    rr_last = 1'b1;
    exp_rd[0] = 32'b0;
    exp_rd[1] = 32'b0;
  endtask

  // One isolated transaction: checks latency, ack exclusivity, owner and rdata.
  task automatic run_one(input string tag, input int m, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata);
    int word;
    word = int'(addr[ADDR_W+1:2]);
    set_req(m, we, sel, addr, wd);
    tick();
    check({tag, ".ack_early"}, {m1_ack, m0_ack}, 32'd0);
    check({tag, ".owner"}, owner, m);
    tick();
    check({tag, ".ack"}, {m1_ack, m0_ack}, (m == 1) ? 32'd2 : 32'd1);
    check({tag, ".rdata"}, (m == 1) ? m1_rdata : m0_rdata, exp_rdata);
    check({tag, ".other_rdata"}, (m == 1) ? m0_rdata : m1_rdata, exp_rd[1-m]);
    exp_rd[m] = exp_rdata;
    if (we) ref_mem[word] = merge(ref_mem[word], wd, sel);
    rr_last = m[0];
    tick();
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  task automatic rand_req(input int m);
    logic [31:0] a;
    a = {$urandom_range(0, 65535), 16'h0};
    a[15:0] = 16'h100 + 16'($urandom_range(0, 15) << 2) + 16'($urandom_range(0, 3));
    set_req(m, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
  endtask

  initial begin
    int w0;
    logic exp_w;
    logic [31:0] exp_data;
    logic [31:0] w_addr, w_wd;
    logic w_we;
    logic [3:0] w_sel;

    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    m0_we = 0; m0_sel = 0; m0_addr = 0; m0_wdata = 0;
    m1_we = 0; m1_sel = 0; m1_addr = 0; m1_wdata = 0;
    do_reset();

    check("reset.owner", owner, 32'd0);
    check("reset.acks", {m1_ack, m0_ack}, 32'd0);
    check("reset.m0_rdata", m0_rdata, 32'd0);
    check("reset.m1_rdata", m1_rdata, 32'd0);
    check("reset.dram", {dram_we, 18'd0, dram_a}, 32'd0);
    check("reset.dram_d", dram_d, 32'd0);

    // Single read.
    preload(32'h40, 32'hDEADBEEF);
    w0 = we_cnt;
    run_one("rd", 0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF);
    check("rd.no_write", we_cnt, w0);

    // Byte-masked write from m1.
    preload(32'h40, 32'h11223344);
    run_one("bmw", 1, 1'b1, 4'b0110, 32'h100, 32'hAABBCCDD, 32'h11223344);
    check("bmw.word", mem[32'h40], 32'h11BBCC44);
    check("bmw.owner", owner, 32'd1);

    // Simultaneous held requests after reset: m0, m1, m0, m1.
    preload(32'h50, 32'h0A0A0A0A);
    preload(32'h51, 32'h0B0B0B0B);
    do_reset();
    set_req(0, 1'b0, 4'h0, 32'h140, 32'h0);
    set_req(1, 1'b0, 4'h0, 32'h144, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("rr.ack0@%0d", k), m0_ack, (k == 2 || k == 8) ? 32'd1 : 32'd0);
      check($sformatf("rr.ack1@%0d", k), m1_ack, (k == 5 || k == 11) ? 32'd1 : 32'd0);
      if (k == 2) check("rr.m0_rdata", m0_rdata, 32'h0A0A0A0A);
      if (k == 5) check("rr.m1_rdata", m1_rdata, 32'h0B0B0B0B);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    rr_last = 1'b1;
    exp_rd[0] = 32'h0A0A0A0A;
    exp_rd[1] = 32'h0B0B0B0B;

    // Write with no lanes enabled.
    preload(32'h41, 32'h12345678);
    w0 = we_cnt;
    run_one("sel0", 0, 1'b1, 4'b0000, 32'h104, 32'hFFFFFFFF, 32'h12345678);
    check("sel0.no_write", we_cnt, w0);
    check("sel0.word", mem[32'h41], 32'h12345678);

    // Byte-offset bits ignored.
    run_one("mask.wr", 0, 1'b1, 4'hF, 32'h103, 32'h0BADF00D, ref_mem[32'h40]);
    run_one("mask.rd", 0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h0BADF00D);

    // Reset during ACCESS of a write.
    preload(32'h42, 32'hA5A5A5A5);
    set_req(0, 1'b1, 4'hF, 32'h108, 32'h55555555);
    tick();
    check("rst.we_in_access", dram_we, 32'd1);
    cpu_rst = 1'b1;
    #1;
    check("rst.we_drop", dram_we, 32'd0);
    check("rst.dram_d", dram_d, 32'd0);
    check("rst.dram_a", dram_a, 32'd0);
    check("rst.outs", {owner, m1_ack, m0_ack}, 32'd0);
    check("rst.rdata", m0_rdata | m1_rdata, 32'd0);
    m0_req = 1'b0;
    tick(); tick();
    check("rst.no_ack", {m1_ack, m0_ack}, 32'd0);
    check("rst.word", mem[32'h42], 32'hA5A5A5A5);
    cpu_rst = 1'b0;
    rr_last = 1'b1;
    exp_rd[0] = 32'b0; exp_rd[1] = 32'b0;
    run_one("rst.reissue", 0, 1'b0, 4'h0, 32'h108, 32'h0, 32'hA5A5A5A5);

    // Random traffic against the model.
    for (int i = 0; i < 16; i++) preload(32'h40 + i, $urandom);
    for (int t = 0; t < 60; t++) begin
      if (!m0_req && !m1_req) begin
        w0 = $urandom_range(1, 3);
        if (w0[0]) rand_req(0);
        if (w0[1]) rand_req(1);
      end
      exp_w  = (m0_req && m1_req) ? ~rr_last : m1_req;
      w_we   = exp_w ? m1_we    : m0_we;
      w_sel  = exp_w ? m1_sel   : m0_sel;
      w_addr = exp_w ? m1_addr  : m0_addr;
      w_wd   = exp_w ? m1_wdata : m0_wdata;
      tick();
      check($sformatf("rnd%0d.owner", t), owner, exp_w);
      check($sformatf("rnd%0d.ack_early", t), {m1_ack, m0_ack}, 32'd0);
      tick();
      exp_data = ref_mem[w_addr[15:2]];
      check($sformatf("rnd%0d.ack", t), {m1_ack, m0_ack}, exp_w ? 32'd2 : 32'd1);
      check($sformatf("rnd%0d.rdata", t), exp_w ? m1_rdata : m0_rdata, exp_data);
      check($sformatf("rnd%0d.other_rdata", t), exp_w ? m0_rdata : m1_rdata, exp_rd[~exp_w]);
      exp_rd[exp_w] = exp_data;
      if (w_we) ref_mem[w_addr[15:2]] = merge(exp_data, w_wd, w_sel);
      rr_last = exp_w;
      tick();
      if (exp_w) m1_req = 1'b0; else m0_req = 1'b0;
      if (!m0_req && $urandom_range(0, 1) == 1) rand_req(0);
      if (!m1_req && $urandom_range(0, 1) == 1) rand_req(1);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();
    for (int i = 0; i < 16; i++)
      check($sformatf("rnd.word%0d", i), mem[32'h40 + i], ref_mem[32'h40 + i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
